output_port_arbiter: RTL and testbench
======================================

// Module: output_port_arbiter
// PURPOSE
//  Wormhole output-port arbiter for one router output (N/S/W/E/Local).
//  Collects the requests that input routers steer to this port, runs one
//  round-robin arbiter per virtual channel, and holds each VC to one input
//  from head flit to tail flit. Higher VC index has fixed priority.
//  One instance per output port, after the input_router port decode.
// PARAMETERS
//  N_INPUTS   4  requesting input ports (all router inputs except own port)
//  NUM_VC     3  virtual channels (= NumVirtChn from the shared package)
//  VC_W       2  VC id width (= VcWidth from the shared package)
// PORTS
//  clk          in   1             clock; all state updates on rising edge
//  arst         in   1             asynchronous reset, active-low
//  req_valid_i  in   N_INPUTS      input i presents a flit for this port
//  req_vc_i     in   N_INPUTS*VC_W VC id of input i's flit
//  req_type_i   in   N_INPUTS*2    flit type: 0 HEAD, 1 BODY, 2 TAIL, 3 HEAD_TAIL
//  req_ready_o  out  N_INPUTS      one-hot grant; flit i accepted this cycle
//  ds_ready_i   in   NUM_VC        downstream buffer can accept a flit on VC v
//  out_valid_o  out  1             a flit is forwarded this cycle
//  out_vc_o     out  VC_W          VC of the forwarded flit
//  out_sel_o    out  N_INPUTS      one-hot mux select for the flit datapath
//  proto_err_o  out  1             one-cycle pulse on BODY/TAIL at an unlocked VC
// BEHAVIOUR
//  - Reset (arst=0): all VC locks cleared, RR pointers=0, proto_err_o=0.
//    req_ready_o, out_sel_o, out_valid_o forced 0 while arst is asserted.
//  - Grant is combinational (0-cycle latency). Lock and pointer state update
//    on the clk edge when the handshake completes (out_valid_o=1).
//  - Per-VC state: UNLOCKED, or LOCKED(owner). Eligibility of input i for VC v:
//    valid, req_vc_i==v, ds_ready_i[v]=1, and either (LOCKED and i==owner) or
//    (UNLOCKED and type is HEAD or HEAD_TAIL).
//  - VC selection: the highest v that has at least one eligible input.
//    Within that VC: LOCKED grants owner; UNLOCKED uses round-robin starting
//    at ptr[v], i.e. ptr[v], ptr[v]+1, ... mod N_INPUTS.
//  - At most one grant per cycle. out_sel_o equals req_ready_o.
//    out_valid_o = |req_ready_o. out_vc_o = VC of the granted flit, else 0.
//  - Transitions on an accepted flit of VC v from input i:
//    HEAD      UNLOCKED -> LOCKED(i)
//    BODY      no change
//    TAIL      LOCKED -> UNLOCKED; ptr[v] <= (i+1) mod N_INPUTS
//    HEAD_TAIL stays UNLOCKED; ptr[v] <= (i+1) mod N_INPUTS
//    Pointer wrap: N_INPUTS-1 -> 0.
//  - LOCKED VC whose owner is idle or has ds_ready_i[v]=0: that VC is
//    skipped and lower VCs may use the port (VC interleaving allowed).
//  - Another input's HEAD on a LOCKED VC is held (ready=0) until the tail.
//  - BODY/TAIL arriving on an UNLOCKED VC is never granted. It raises
//    proto_err_o for one cycle: registered, pulses the cycle after detection,
//    and repeats each cycle the condition persists.
//  - The owner's HEAD while its VC is LOCKED is treated as BODY (no relock).
//  - arst asserted mid-packet drops all locks. Partial packets are lost.
//    The sender must restart with a HEAD.
// STRUCTURE
//  - Shared package gets: flit-type enum (HEAD/BODY/TAIL/HEAD_TAIL),
//    NumVirtChn, VcWidth, and the port index constants already used by
//    input_router.
//  - Sub-module rr_arbiter (N-way, pointer input, one-hot grant output),
//    instantiated NUM_VC times.
//  - Top level holds the lock/owner/ptr registers, VC priority select and
//    error flag.
// TESTING
//  1 Single HEAD_TAIL: in1 VC0, ds_ready=3'b111 -> req_ready=4'b0010 same
//    cycle, out_vc=0, ptr[0]=2 next cycle.
//  2 Wormhole lock: in0 HEAD VC1, then in2 HEAD VC1 with in0 BODY,BODY,TAIL
//    -> in0 granted 4 cycles, in2 granted on cycle 5, ptr[1]=1 after in0 TAIL.
//  3 VC priority: in0 HEAD VC0 and in3 HEAD VC2 same cycle -> in3 first;
//    in0 granted once VC2 has no eligible flit.
//  4 Fairness/wrap: all 4 inputs send HEAD_TAIL on VC0 every cycle
//    -> grants 0,1,2,3,0 cyclically.
//  5 Backpressure and interleave: VC2 locked to in1, ds_ready[2]=0, in2 HEAD
//    VC0 -> in2 granted; VC2 lock kept; in1 resumes when ds_ready[2]=1.
//  6 Error/reset: BODY on unlocked VC0 -> no grant, proto_err_o=1 next
//    cycle; arst=0 while VC1 locked -> outputs 0, VC1 unlocked after release.

Source files
------------

// File: rtl/output_port_arbiter_pkg.sv
// output_port_arbiter_pkg: router-wide flit types, VC sizing and port indices.
package output_port_arbiter_pkg;
    typedef enum logic [1:0] {
        HEAD      = 2'd0,
        BODY      = 2'd1,
        TAIL      = 2'd2,
        HEAD_TAIL = 2'd3
    } flit_type_e;
    localparam int NumVirtChn = 3;
    localparam int VcWidth    = 2;
    localparam int NumInputs  = 4;
    localparam logic [2:0] PortNorth = 3'd0;
    localparam logic [2:0] PortSouth = 3'd1;
    localparam logic [2:0] PortWest  = 3'd2;
    localparam logic [2:0] PortEast  = 3'd3;
    localparam logic [2:0] PortLocal = 3'd4;
endpackage

// File: rtl/output_port_arbiter_rr_arbiter.sv
// rr_arbiter: N-way round-robin, searches upward from ptr_i and wraps to 0.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + (PW+1)'(k);
            idx = sum >= (PW+1)'(N) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: wormhole arbiter for one router output port.
// Each VC is locked to one input from head to tail; higher VC index wins.
module output_port_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter int N_INPUTS = NumInputs,
    parameter int NUM_VC   = NumVirtChn,
    parameter int VC_W     = VcWidth
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [N_INPUTS-1:0]      req_valid_i,
    input  logic [N_INPUTS*VC_W-1:0] req_vc_i,
    input  logic [N_INPUTS*2-1:0]    req_type_i,
    output logic [N_INPUTS-1:0]      req_ready_o,
    input  logic [NUM_VC-1:0]        ds_ready_i,
    output logic                     out_valid_o,
    output logic [VC_W-1:0]          out_vc_o,
    output logic [N_INPUTS-1:0]      out_sel_o,
    output logic                     proto_err_o
);
    localparam int PW = $clog2(N_INPUTS);

    logic [NUM_VC-1:0]                lock_q, lock_d;
    logic [NUM_VC-1:0][PW-1:0]        owner_q, owner_d, ptr_q, ptr_d;
    logic                             err_q, err_d;
    logic [NUM_VC-1:0][N_INPUTS-1:0]  elig, vc_gnt;
    logic [N_INPUTS-1:0]              grant;
    logic [VC_W-1:0]                  sel_vc;
    logic [PW-1:0]                    gnt_idx, nxt_ptr;
    flit_type_e                       gnt_type, typ;

    // A locked VC only admits its owner, whatever flit type the owner sends.
    always_comb begin
        elig  = '0;
        err_d = 1'b0;
        typ   = HEAD;
        for (int v = 0; v < NUM_VC; v++) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                typ = flit_type_e'(req_type_i[i*2 +: 2]);
                if (req_valid_i[i] && req_vc_i[i*VC_W +: VC_W] == VC_W'(v)) begin
                    if (lock_q[v])
                        elig[v][i] = ds_ready_i[v] && owner_q[v] == PW'(i);
                    else if (typ == HEAD || typ == HEAD_TAIL)
                        elig[v][i] = ds_ready_i[v];
                    else
                        err_d = 1'b1;
                end
            end
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_arb
        rr_arbiter #(.N(N_INPUTS)) u_arb (
            .req_i (elig[v]),
            .ptr_i (ptr_q[v]),
            .gnt_o (vc_gnt[v])
        );
    end

    always_comb begin
        sel_vc   = '0;
        grant    = '0;
        gnt_idx  = '0;
        gnt_type = HEAD;
        for (int v = 0; v < NUM_VC; v++) begin
            if (|elig[v]) begin
                sel_vc = VC_W'(v);
                grant  = vc_gnt[v];
            end
        end
        if (!arst)
            grant = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (grant[i]) begin
                gnt_idx  = PW'(i);
                gnt_type = flit_type_e'(req_type_i[i*2 +: 2]);
            end
        end
    end

    assign req_ready_o = grant;
    assign out_sel_o   = grant;
    assign out_valid_o = |grant;
    assign out_vc_o    = out_valid_o ? sel_vc : '0;
    assign proto_err_o = err_q;

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        nxt_ptr = gnt_idx == PW'(N_INPUTS-1) ? '0 : gnt_idx + 1'b1;
        if (out_valid_o) begin
            if (lock_q[sel_vc]) begin
                if (gnt_type == TAIL || gnt_type == HEAD_TAIL) begin
                    lock_d[sel_vc] = 1'b0;
                    ptr_d[sel_vc]  = nxt_ptr;
                end
            end else if (gnt_type == HEAD) begin
                lock_d[sel_vc]  = 1'b1;
                owner_d[sel_vc] = gnt_idx;
            end else begin
                ptr_d[sel_vc] = nxt_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            lock_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed vectors checked against a per-cycle reference model.
module tb_output_port_arbiter;
    import output_port_arbiter_pkg::*;
    localparam int N  = 4;
    localparam int NV = 3;

    logic          clk = 1'b0, arst = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [2*N-1:0] req_vc = '0, req_type = '0;
    logic [NV-1:0] ds_ready = '1;
    logic [N-1:0]  req_ready, out_sel;
    logic          out_valid, proto_err;
    logic [1:0]    out_vc;

    int checks = 0, errors = 0;
    int owner[NV] = '{-1, -1, -1};
    int ptr[NV]   = '{0, 0, 0};
    int e_in = -1, e_v = 0, t = 0, c = 0;
    logic e_err_nxt = 1'b0, e_err = 1'b0;
    logic [N-1:0] exp_g;

    output_port_arbiter dut (
        .clk(clk), .arst(arst), .req_valid_i(req_valid), .req_vc_i(req_vc),
        .req_type_i(req_type), .req_ready_o(req_ready), .ds_ready_i(ds_ready),
        .out_valid_o(out_valid), .out_vc_o(out_vc), .out_sel_o(out_sel),
        .proto_err_o(proto_err)
    );

    always #5 clk = ~clk;

    function automatic int vc_of(input int i);
        return int'(req_vc[2*i +: 2]);
    endfunction

    function automatic int ty_of(input int i);
        return int'(req_type[2*i +: 2]);
    endfunction

    function automatic logic [7:0] pk(input logic [1:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] v, input logic [7:0] cv, input logic [7:0] ty, input logic [2:0] d);
        @(posedge clk);
        #1;
        req_valid = v;
        req_vc    = cv;
        req_type  = ty;
        ds_ready  = d;
        #1;
    endtask

    // Reference: highest VC with a flit it may legally take; owner if locked, else RR scan.
    always @(negedge clk) begin
        e_in      = -1;
        e_v       = 0;
        e_err_nxt = 1'b0;
        for (int i = 0; i < N; i++)
            if (req_valid[i] && vc_of(i) < NV && owner[vc_of(i)] < 0 && (ty_of(i) == 1 || ty_of(i) == 2))
                e_err_nxt = 1'b1;
        if (arst) begin
            for (int v = NV - 1; v >= 0; v--) begin
                if (e_in < 0 && ds_ready[v]) begin
                    if (owner[v] >= 0) begin
                        if (req_valid[owner[v]] && vc_of(owner[v]) == v) e_in = owner[v];
                    end else begin
                        for (int k = 0; k < N; k++) begin
                            c = (ptr[v] + k) % N;
                            if (e_in < 0 && req_valid[c] && vc_of(c) == v && (ty_of(c) == 0 || ty_of(c) == 3))
                                e_in = c;
                        end
                    end
                    if (e_in >= 0) e_v = v;
                end
            end
        end
        exp_g = '0;
        if (e_in >= 0) exp_g[e_in] = 1'b1;
        chk("ready", req_ready, exp_g);
        chk("sel", out_sel, exp_g);
        chk("valid", out_valid, e_in >= 0);
        chk("vc", out_vc, e_in >= 0 ? e_v : 0);
        chk("err", proto_err, arst ? e_err : 1'b0);
    end

    always @(posedge clk) begin
        if (!arst) begin
            owner = '{-1, -1, -1};
            ptr   = '{0, 0, 0};
            e_err = 1'b0;
        end else begin
            e_err = e_err_nxt;
            if (e_in >= 0) begin
                t = ty_of(e_in);
                if (owner[e_v] < 0) begin
                    if (t == 0) owner[e_v] = e_in;
                    else ptr[e_v] = (e_in + 1) % N;
                end else if (t == 2 || t == 3) begin
                    owner[e_v] = -1;
                    ptr[e_v]   = (e_in + 1) % N;
                end
            end
        end
    end

    initial begin
        cyc(4'b0001, pk(0, 0, 0, 0), pk(0, 0, 0, HEAD), 3'b111);
        chk("rst ready", req_ready, 4'b0000);
        chk("rst valid", out_valid, 1'b0);
        chk("rst err", proto_err, 1'b0);
        cyc(4'b0000, 8'h00, 8'h00, 3'b111);
        arst = 1'b1;
        #1;
        // single HEAD_TAIL, then fairness with wrap from ptr[0]=2
        cyc(4'b0010, pk(0, 0, 0, 0), pk(0, 0, HEAD_TAIL, 0), 3'b111);
        chk("t1 ready", req_ready, 4'b0010);
        chk("t1 vc", out_vc, 2'd0);
        cyc(4'b1111, 8'h00, pk(HEAD_TAIL, HEAD_TAIL, HEAD_TAIL, HEAD_TAIL), 3'b111);
        chk("t1 ptr", ptr[0], 2);
        chk("t4 g0", req_ready, 4'b0100);
        cyc(4'b1111, 8'h00, pk(HEAD_TAIL, HEAD_TAIL, HEAD_TAIL, HEAD_TAIL), 3'b111);
        chk("t4 g1", req_ready, 4'b1000);
        cyc(4'b1111, 8'h00, pk(HEAD_TAIL, HEAD_TAIL, HEAD_TAIL, HEAD_TAIL), 3'b111);
        chk("t4 g2", req_ready, 4'b0001);
        cyc(4'b1111, 8'h00, pk(HEAD_TAIL, HEAD_TAIL, HEAD_TAIL, HEAD_TAIL), 3'b111);
        chk("t4 g3", req_ready, 4'b0010);
        // wormhole lock on VC1
        cyc(4'b0001, pk(0, 0, 0, 1), pk(0, 0, 0, HEAD), 3'b111);
        chk("t2 head", req_ready, 4'b0001);
        cyc(4'b0101, pk(0, 1, 0, 1), pk(0, HEAD, 0, BODY), 3'b111);
        chk("t2 body1", req_ready, 4'b0001);
        cyc(4'b0101, pk(0, 1, 0, 1), pk(0, HEAD, 0, BODY), 3'b111);
        chk("t2 body2", req_ready, 4'b0001);
        cyc(4'b0101, pk(0, 1, 0, 1), pk(0, HEAD, 0, TAIL), 3'b111);
        chk("t2 tail", req_ready, 4'b0001);
        cyc(4'b0100, pk(0, 1, 0, 0), pk(0, HEAD, 0, 0), 3'b111);
        chk("t2 ptr", ptr[1], 1);
        chk("t2 in2", req_ready, 4'b0100);
        cyc(4'b0100, pk(0, 1, 0, 0), pk(0, TAIL, 0, 0), 3'b111);
        chk("t2 in2 tail", req_ready, 4'b0100);
        // VC priority
        cyc(4'b1001, pk(2, 0, 0, 0), pk(HEAD, 0, 0, HEAD), 3'b111);
        chk("t3 hi", req_ready, 4'b1000);
        chk("t3 hi vc", out_vc, 2'd2);
        cyc(4'b1001, pk(2, 0, 0, 0), pk(TAIL, 0, 0, HEAD), 3'b111);
        chk("t3 hi tail", req_ready, 4'b1000);
        cyc(4'b0001, pk(0, 0, 0, 0), pk(0, 0, 0, HEAD), 3'b111);
        chk("t3 lo", req_ready, 4'b0001);
        chk("t3 lo vc", out_vc, 2'd0);
        cyc(4'b0001, pk(0, 0, 0, 0), pk(0, 0, 0, TAIL), 3'b111);
        chk("t3 lo tail", req_ready, 4'b0001);
        // backpressure on locked VC2 lets VC0 interleave
        cyc(4'b0010, pk(0, 0, 2, 0), pk(0, 0, HEAD, 0), 3'b111);
        chk("t5 lock", req_ready, 4'b0010);
        cyc(4'b0110, pk(0, 0, 2, 0), pk(0, HEAD, BODY, 0), 3'b011);
        chk("t5 inter", req_ready, 4'b0100);
        chk("t5 inter vc", out_vc, 2'd0);
        cyc(4'b0110, pk(0, 0, 2, 0), pk(0, TAIL, BODY, 0), 3'b011);
        chk("t5 inter2", req_ready, 4'b0100);
        cyc(4'b0010, pk(0, 0, 2, 0), pk(0, 0, TAIL, 0), 3'b111);
        chk("t5 owner", owner[2], 1);
        chk("t5 resume", req_ready, 4'b0010);
        chk("t5 resume vc", out_vc, 2'd2);
        // protocol error and reset mid-packet
        cyc(4'b0001, pk(0, 0, 0, 0), pk(0, 0, 0, BODY), 3'b111);
        chk("t6 nogrant", out_valid, 1'b0);
        cyc(4'b0000, 8'h00, 8'h00, 3'b111);
        chk("t6 err", proto_err, 1'b1);
        cyc(4'b0000, 8'h00, 8'h00, 3'b111);
        chk("t6 err clr", proto_err, 1'b0);
        cyc(4'b0010, pk(0, 0, 1, 0), pk(0, 0, HEAD, 0), 3'b111);
        chk("t6 lock", req_ready, 4'b0010);
        cyc(4'b0010, pk(0, 0, 1, 0), pk(0, 0, BODY, 0), 3'b111);
        arst = 1'b0;
        #1;
        chk("t6 rst ready", req_ready, 4'b0000);
        chk("t6 rst sel", out_sel, 4'b0000);
        chk("t6 rst valid", out_valid, 1'b0);
        cyc(4'b0010, pk(0, 0, 1, 0), pk(0, 0, BODY, 0), 3'b111);
        chk("t6 rst hold", req_ready, 4'b0000);
        cyc(4'b0010, pk(0, 0, 1, 0), pk(0, 0, BODY, 0), 3'b111);
        arst = 1'b1;
        #1;
        chk("t6 unlocked", req_ready, 4'b0000);
        cyc(4'b1000, pk(1, 0, 0, 0), pk(HEAD, 0, 0, 0), 3'b111);
        chk("t6 err2", proto_err, 1'b1);
        chk("t6 relock", req_ready, 4'b1000);
        cyc(4'b1000, pk(1, 0, 0, 0), pk(TAIL, 0, 0, 0), 3'b111);
        chk("t6 tail", req_ready, 4'b1000);
        cyc(4'b0000, 8'h00, 8'h00, 3'b111);
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
